// File: rtl/ws2812b_pixel_feeder_if.sv
// Bus bundle for ws2812b_pixel_feeder: byte register write/read port plus
// the valid/ready pixel stream toward the WS2812B bit encoder.
interface ws2812b_pixel_feeder_if;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [1:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [23:0] px_data;
    logic        px_valid;
    logic        px_latch;
    logic        px_ready;

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        output rd_data,
        output px_data,
        output px_valid,
        output px_latch,
        input  px_ready
    );

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr,
        input  rd_data,
        input  px_data,
        input  px_valid,
        input  px_latch,
        output px_ready
    );
endinterface

// File: rtl/ws2812b_pixel_feeder.sv
// Assembles byte writes into GRB pixels, queues them and hands them to the encoder.
// Optional per-pixel repeat count enabled by defining WS2812B_FEEDER_REPEAT_EN.
//
// state | meaning
// PH_G  | next PIXEL write is the green byte
// PH_R  | next PIXEL write is the red byte
// PH_B  | next PIXEL write is blue; completes and pushes the pixel
module ws2812b_pixel_feeder #(
    parameter int FIFO_DEPTH = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    ws2812b_pixel_feeder_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        PH_G = 2'd0,
        PH_R = 2'd1,
        PH_B = 2'd2
    } phase_t;

    phase_t         phase;
    logic [7:0]     g_byte;
    logic [7:0]     r_byte;
    logic           latch_armed;
    logic           ovf;

    logic [23:0]    fifo_data  [FIFO_DEPTH];
    logic           fifo_latch [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    logic           empty;
    logic           full;
    logic           pixel_wr;
    logic           ctrl_wr;
    logic           push_req;
    logic           push;
    logic           xfer;
    logic           pop;
    logic           last_copy;

`ifdef WS2812B_FEEDER_REPEAT_EN
    logic [7:0]     fifo_rep [FIFO_DEPTH];
    logic [7:0]     repeat_reg;
    logic [7:0]     copy_rem;
    logic           copy_loaded;
    logic [7:0]     eff_rem;
    logic           repeat_wr;
`endif

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign pixel_wr = bus.wr_en && (bus.wr_addr == 2'd0);
    assign ctrl_wr  = bus.wr_en && (bus.wr_addr == 2'd1);
    assign push_req = pixel_wr && (phase == PH_B);
    // A full FIFO rejects the push even if the head leaves this same cycle.
    assign push     = push_req && !full;
    assign xfer     = !empty && bus.px_ready;
    assign pop      = xfer && last_copy;

`ifdef WS2812B_FEEDER_REPEAT_EN
    assign repeat_wr = bus.wr_en && (bus.wr_addr == 2'd2);
    // Until the head has been transferred once, its remaining count comes straight from the entry.
    assign eff_rem   = copy_loaded ? copy_rem : fifo_rep[rd_ptr];
    assign last_copy = (eff_rem == 8'd0);
`else
    assign last_copy = 1'b1;
`endif

    assign bus.px_valid = !empty;
    assign bus.px_data  = empty ? 24'h000000 : fifo_data[rd_ptr];
    assign bus.px_latch = !empty && fifo_latch[rd_ptr] && last_copy;

    always_comb begin
        bus.rd_data = 8'h00;
        case (bus.rd_addr)
            2'd0: bus.rd_data = {2'b00, latch_armed, phase, ovf, full, empty};
            2'd1: bus.rd_data = 8'(count);
`ifdef WS2812B_FEEDER_REPEAT_EN
            2'd2: bus.rd_data = repeat_reg;
`endif
            default: bus.rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr]  <= {g_byte, r_byte, bus.wr_data};
            fifo_latch[wr_ptr] <= latch_armed;
`ifdef WS2812B_FEEDER_REPEAT_EN
            fifo_rep[wr_ptr]   <= repeat_reg;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase       <= PH_G;
            g_byte      <= 8'h00;
            r_byte      <= 8'h00;
            latch_armed <= 1'b0;
            ovf         <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
`ifdef WS2812B_FEEDER_REPEAT_EN
            repeat_reg  <= 8'h00;
            copy_rem    <= 8'h00;
            copy_loaded <= 1'b0;
`endif
        end else begin
            if (pixel_wr) begin
                case (phase)
                    PH_G: begin
                        g_byte <= bus.wr_data;
                        phase  <= PH_R;
                    end
                    PH_R: begin
                        r_byte <= bus.wr_data;
                        phase  <= PH_B;
                    end
                    default: phase <= PH_G;
                endcase
            end

            // The latch flag is consumed by the pixel even when that pixel is dropped.
            if (push_req) begin
                latch_armed <= 1'b0;
                if (full) ovf <= 1'b1;
            end

            if (ctrl_wr) begin
                if (bus.wr_data[0]) latch_armed <= 1'b1;
                if (bus.wr_data[1]) begin
                    phase  <= PH_G;
                    g_byte <= 8'h00;
                    r_byte <= 8'h00;
                end
                if (bus.wr_data[7]) ovf <= 1'b0;
            end

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

`ifdef WS2812B_FEEDER_REPEAT_EN
            if (repeat_wr) repeat_reg <= bus.wr_data;

            if (xfer) begin
                if (last_copy) begin
                    copy_loaded <= 1'b0;
                    copy_rem    <= 8'h00;
                end else begin
                    copy_loaded <= 1'b1;
                    copy_rem    <= eff_rem - 8'd1;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_ws2812b_pixel_feeder.sv
// Directed bench for ws2812b_pixel_feeder; builds with or without WS2812B_FEEDER_REPEAT_EN.
module tb_ws2812b_pixel_feeder;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ws2812b_pixel_feeder_if bus_if ();

    ws2812b_pixel_feeder #(.FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_addr = a;
        bus_if.wr_data = d;
        @(negedge clk);
        bus_if.wr_en   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
        bus_if.rd_addr = a;
        #1;
        chk(tag, {24'h0, bus_if.rd_data}, {24'h0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [23:0] exp_px;

        bus_if.wr_en    = 1'b0;
        bus_if.wr_addr  = 2'd0;
        bus_if.wr_data  = 8'h00;
        bus_if.rd_addr  = 2'd0;
        bus_if.px_ready = 1'b0;
        rst_n           = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_valid", {31'h0, bus_if.px_valid}, 32'd0);
        chk("rst_latch", {31'h0, bus_if.px_latch}, 32'd0);
        chk("rst_data",  {8'h0, bus_if.px_data}, 32'd0);
        rd_chk("rst_status", 2'd0, 8'h01);
        rd_chk("rst_count",  2'd1, 8'h00);
        rd_chk("rst_repeat", 2'd2, 8'h00);
        rst_n = 1'b1;

        // basic pixel, encoder ready
        bus_if.px_ready = 1'b1;
        wr(2'd0, 8'h12);
        rd_chk("t1_phase_r", 2'd0, 8'h09);
        wr(2'd0, 8'h34);
        wr(2'd0, 8'h56);
        chk("t1_valid", {31'h0, bus_if.px_valid}, 32'd1);
        chk("t1_data",  {8'h0, bus_if.px_data}, 32'h123456);
        chk("t1_latch", {31'h0, bus_if.px_latch}, 32'd0);
        step();
        chk("t1_popped", {31'h0, bus_if.px_valid}, 32'd0);
        rd_chk("t1_status", 2'd0, 8'h01);

        // overflow with encoder stalled
        bus_if.px_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr(2'd0, 8'(8'h10 + i));
            wr(2'd0, 8'(8'h20 + i));
            wr(2'd0, 8'(8'h30 + i));
            if (i == 3) rd_chk("t2_full", 2'd0, 8'h02);
        end
        rd_chk("t2_status", 2'd0, 8'h06);
        rd_chk("t2_count",  2'd1, 8'h04);
        step();
        step();
        chk("t2_hold", {8'h0, bus_if.px_data}, 32'h102030);
        bus_if.px_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_px = {8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i)};
            chk($sformatf("t2_valid%0d", i), {31'h0, bus_if.px_valid}, 32'd1);
            chk($sformatf("t2_px%0d", i), {8'h0, bus_if.px_data}, {8'h0, exp_px});
            step();
        end
        chk("t2_drained", {31'h0, bus_if.px_valid}, 32'd0);
        rd_chk("t2_ovf", 2'd0, 8'h05);
        wr(2'd1, 8'h80);
        rd_chk("t2_ovf_clr", 2'd0, 8'h01);

        // latch flag on a single pixel
        bus_if.px_ready = 1'b0;
        wr(2'd1, 8'h01);
        rd_chk("t3_armed", 2'd0, 8'h21);
        wr(2'd0, 8'hFF); wr(2'd0, 8'h00); wr(2'd0, 8'h00);
        wr(2'd0, 8'h00); wr(2'd0, 8'h00); wr(2'd0, 8'h11);
        rd_chk("t3_status", 2'd0, 8'h00);
        chk("t3_data0",  {8'h0, bus_if.px_data}, 32'hFF0000);
        chk("t3_latch0", {31'h0, bus_if.px_latch}, 32'd1);
        step();
        bus_if.px_ready = 1'b1;
        step();
        chk("t3_data1",  {8'h0, bus_if.px_data}, 32'h000011);
        chk("t3_latch1", {31'h0, bus_if.px_latch}, 32'd0);
        step();
        chk("t3_empty", {31'h0, bus_if.px_valid}, 32'd0);
        bus_if.px_ready = 1'b0;

        // partial pixel abort
        wr(2'd0, 8'hAA);
        wr(2'd0, 8'hBB);
        rd_chk("t4_phase_b", 2'd0, 8'h11);
        wr(2'd1, 8'h02);
        rd_chk("t4_abort", 2'd0, 8'h01);
        wr(2'd0, 8'h01); wr(2'd0, 8'h02); wr(2'd0, 8'h03);
        rd_chk("t4_status", 2'd0, 8'h00);
        rd_chk("t4_count",  2'd1, 8'h01);
        chk("t4_data", {8'h0, bus_if.px_data}, 32'h010203);

        // push and pop in the same cycle
        wr(2'd0, 8'h44);
        wr(2'd0, 8'h55);
        step();
        bus_if.wr_en    = 1'b1;
        bus_if.wr_addr  = 2'd0;
        bus_if.wr_data  = 8'h66;
        bus_if.px_ready = 1'b1;
        step();
        bus_if.wr_en    = 1'b0;
        bus_if.px_ready = 1'b0;
        rd_chk("t5_count", 2'd1, 8'h01);
        chk("t5_data",  {8'h0, bus_if.px_data}, 32'h445566);
        chk("t5_valid", {31'h0, bus_if.px_valid}, 32'd1);
        step();
        bus_if.px_ready = 1'b1;
        step();
        chk("t5_empty", {31'h0, bus_if.px_valid}, 32'd0);
        bus_if.px_ready = 1'b0;

        // addr 3 and repeat register
        wr(2'd3, 8'hFF);
        rd_chk("a3_read", 2'd3, 8'h00);
        rd_chk("a3_status", 2'd0, 8'h01);
        wr(2'd2, 8'h02);
`ifdef WS2812B_FEEDER_REPEAT_EN
        rd_chk("t6_rep", 2'd2, 8'h02);
`else
        rd_chk("t6_rep", 2'd2, 8'h00);
`endif
        wr(2'd1, 8'h01);
        wr(2'd0, 8'h0A); wr(2'd0, 8'h0B); wr(2'd0, 8'h0C);
        step();
        bus_if.px_ready = 1'b1;
`ifdef WS2812B_FEEDER_REPEAT_EN
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("t6_data%0d", c), {8'h0, bus_if.px_data}, 32'h0A0B0C);
            chk($sformatf("t6_latch%0d", c), {31'h0, bus_if.px_latch}, (c == 2) ? 32'd1 : 32'd0);
            step();
        end
`else
        chk("t6_data0",  {8'h0, bus_if.px_data}, 32'h0A0B0C);
        chk("t6_latch0", {31'h0, bus_if.px_latch}, 32'd1);
        step();
`endif
        chk("t6_empty", {31'h0, bus_if.px_valid}, 32'd0);
        bus_if.px_ready = 1'b0;

        // reset with pixels queued
        wr(2'd0, 8'h01); wr(2'd0, 8'h02); wr(2'd0, 8'h03);
        wr(2'd0, 8'h04); wr(2'd0, 8'h05); wr(2'd0, 8'h06);
        rd_chk("t7_count", 2'd1, 8'h02);
        wr(2'd0, 8'h07);
        rst_n = 1'b0;
        bus_if.px_ready = 1'b1;
        step();
        rst_n = 1'b1;
        bus_if.px_ready = 1'b0;
        chk("t7_valid", {31'h0, bus_if.px_valid}, 32'd0);
        chk("t7_data",  {8'h0, bus_if.px_data}, 32'd0);
        rd_chk("t7_status", 2'd0, 8'h01);
        rd_chk("t7_repeat", 2'd2, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
